// File: rtl/sram_pkg.sv
// Shared types and constants for the single-bit SRAM byte engine.
package sram_pkg;

   // Engine sequencing states; one SETUP/STROBE/HOLD pass moves one bit.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_DONE
   } state_t;

   // Default phase lengths in clock cycles per bit.
   localparam int DEF_SETUP_CYC  = 2;
   localparam int DEF_STROBE_CYC = 4;
   localparam int DEF_HOLD_CYC   = 1;

   // SRAM control strobes are active-low.
   localparam logic STROBE_ON  = 1'b0;
   localparam logic STROBE_OFF = 1'b1;

   // Width of the phase down-counter: enough to hold the longest phase minus one.
   function automatic int phase_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/sram_bit_engine_timer.sv
// Loadable down-counter with terminal count; times the SETUP/STROBE/HOLD phases.
module sram_phase_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt;

   // Load the phase length minus one on entry, then count down and park at zero.
   // NOTE: sequential state is always assigned with <= so every flop samples the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/sram_bit_engine.sv
// Byte read/write engine that serialises each byte into eight single-bit SRAM cycles, MSB first.
module sram_bit_engine
   import sram_pkg::*;
#(
   parameter int SETUP_CYC  = DEF_SETUP_CYC,
   parameter int STROBE_CYC = DEF_STROBE_CYC,
   parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       sram_cs,
   output logic       sram_oe,
   output logic       sram_we,
   output logic       io_oe,
   output logic       io_dout,
   input  logic       io_din
);

   localparam int PH_W = phase_width(SETUP_CYC, STROBE_CYC, HOLD_CYC);
   localparam logic [PH_W-1:0] SETUP_LD  = PH_W'(SETUP_CYC - 1);
   localparam logic [PH_W-1:0] STROBE_LD = PH_W'(STROBE_CYC - 1);
   localparam logic [PH_W-1:0] HOLD_LD   = PH_W'(HOLD_CYC - 1);

   state_t          state, state_nxt;
   logic            is_write;
   logic [7:0]      sreg;
   logic [2:0]      bit_cnt;
   logic            accept;
   logic            busy;
   logic            last_bit;
   logic            tmr_load;
   logic [PH_W-1:0] tmr_val;
   logic            tmr_tc;

   assign req_ready = (state == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign busy      = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);
   assign last_bit  = (bit_cnt == 3'd7);

   sram_phase_timer #(
      .W(PH_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; each phase exit reloads the timer with the following phase length.
   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_SETUP;
               tmr_load  = 1'b1;
               tmr_val   = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (tmr_tc) begin
               state_nxt = ST_STROBE;
               tmr_load  = 1'b1;
               tmr_val   = STROBE_LD;
            end
         end
         ST_STROBE: begin
            if (tmr_tc) begin
               state_nxt = ST_HOLD;
               tmr_load  = 1'b1;
               tmr_val   = HOLD_LD;
            end
         end
         ST_HOLD: begin
            if (tmr_tc) begin
               if (last_bit) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_SETUP;
                  tmr_load  = 1'b1;
                  tmr_val   = SETUP_LD;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Byte shift register, bit counter and read-data capture.
   // NOTE: the shift register is reset so io_dout comes out of reset at a defined 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         is_write  <= 1'b0;
         sreg      <= 8'h00;
         bit_cnt   <= 3'd0;
         rsp_rdata <= 8'h00;
      end else if (accept) begin
         is_write <= req_write;
         sreg     <= req_wdata;
         bit_cnt  <= 3'd0;
      end else if (state == ST_STROBE && tmr_tc && !is_write) begin
         sreg <= {sreg[6:0], io_din};
      end else if (state == ST_HOLD && tmr_tc && !last_bit) begin
         bit_cnt <= bit_cnt + 3'd1;
         if (is_write) sreg <= {sreg[6:0], 1'b0};
      end else if (state == ST_DONE && !is_write) begin
         rsp_rdata <= sreg;
      end
   end

   // Registered pin drives, decoded from the current state so they trail it by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sram_cs   <= STROBE_OFF;
         sram_oe   <= STROBE_OFF;
         sram_we   <= STROBE_OFF;
         io_oe     <= 1'b0;
         io_dout   <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         sram_cs   <= busy ? STROBE_ON : STROBE_OFF;
         sram_we   <= (state == ST_STROBE && is_write)  ? STROBE_ON : STROBE_OFF;
         sram_oe   <= (state == ST_STROBE && !is_write) ? STROBE_ON : STROBE_OFF;
         io_oe     <= busy && is_write;
         io_dout   <= sreg[7];
         rsp_valid <= (state == ST_DONE);
      end
   end

endmodule

// File: tb/tb_sram_bit_engine.sv
// Scoreboard bench for sram_bit_engine: default-timing instance plus a 1/1/1 timing instance.
module tb_sram_bit_engine;
   import sram_pkg::*;

   localparam int LAT_DEF  = 57;   // 8*7+1
   localparam int LAT_FAST = 25;   // 8*3+1
   localparam int B2B_GAP  = 58;   // 8*7+2

   typedef struct {
      logic       wr;
      logic [7:0] data;
      int         acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Default-timing instance.
   logic       req_valid = 1'b0, req_write = 1'b0;
   logic [7:0] req_wdata = 8'h00;
   logic       req_ready, rsp_valid, sram_cs, sram_oe, sram_we, io_oe, io_dout;
   logic [7:0] rsp_rdata;
   logic       io_din = 1'b0;

   sram_bit_engine dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
      .io_oe(io_oe), .io_dout(io_dout), .io_din(io_din)
   );

   // Minimum-timing instance.
   logic       req_valid_f = 1'b0, req_write_f = 1'b0;
   logic [7:0] req_wdata_f = 8'h00;
   logic       req_ready_f, rsp_valid_f, sram_cs_f, sram_oe_f, sram_we_f, io_oe_f, io_dout_f;
   logic [7:0] rsp_rdata_f;
   logic       io_din_f = 1'b0;

   sram_bit_engine #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_f (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_f), .req_ready(req_ready_f), .req_write(req_write_f), .req_wdata(req_wdata_f),
      .rsp_valid(rsp_valid_f), .rsp_rdata(rsp_rdata_f),
      .sram_cs(sram_cs_f), .sram_oe(sram_oe_f), .sram_we(sram_we_f),
      .io_oe(io_oe_f), .io_dout(io_dout_f), .io_din(io_din_f)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Scoreboards and response monitors.
   exp_t q[$];
   exp_t qf[$];
   exp_t me, mef;
   int   rsp_cnt = 0;

   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         rsp_cnt++;
         if (q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'd0);
         end else begin
            me = q.pop_front();
            check("rsp_latency", cyc - me.acc, LAT_DEF);
            check("cs_high_at_rsp", 32'(sram_cs), 32'd1);
            if (!me.wr) check("rsp_rdata", 32'(rsp_rdata), 32'(me.data));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && rsp_valid_f) begin
         if (qf.size() == 0) begin
            check("rsp_f_unexpected", 32'(rsp_valid_f), 32'd0);
         end else begin
            mef = qf.pop_front();
            check("rsp_f_latency", cyc - mef.acc, LAT_FAST);
         end
      end
   end

   // Pin-level monitor: write strobe windows, data stability, strobe exclusivity.
   logic       prev_we = 1'b1;
   logic       win_dout = 1'b0;
   logic [7:0] we_bits = 8'h00;
   int we_len = 0, we_cnt = 0, we_badw = 0, dout_bad = 0, excl_bad = 0, io_oe_cnt = 0;

   always @(negedge clk) begin
      if (sram_we === 1'b0) begin
         if (prev_we) begin
            we_cnt++;
            we_bits  = {we_bits[6:0], io_dout};
            win_dout = io_dout;
            we_len   = 0;
         end else if (io_dout !== win_dout) begin
            dout_bad++;
         end
         we_len++;
      end else if (!prev_we && we_len != DEF_STROBE_CYC) begin
         we_badw++;
      end
      prev_we = sram_we;
      if (!sram_we && !sram_oe)     excl_bad++;
      if (io_oe && !sram_oe)        excl_bad++;
      if (!sram_we_f && !sram_oe_f) excl_bad++;
      if (io_oe_f && !sram_oe_f)    excl_bad++;
      if (io_oe) io_oe_cnt++;
   end

   // SRAM read model: present the next pattern bit MSB first as each read strobe opens.
   logic [7:0] rd_pat = 8'h00;
   int         oe_falls = 0;
   always @(negedge sram_oe) begin
      io_din = rd_pat[3'(7 - (oe_falls % 8))];
      oe_falls++;
   end

   task automatic do_req(input logic wr, input logic [7:0] wd, input logic [7:0] exp_rd, output int acc);
      int n;
      n   = 0;
      acc = -1;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_wdata = wd;
      while (1) begin
         if (req_ready) begin
            acc = cyc + 1;
            q.push_back('{wr, wr ? wd : exp_rd, acc});
            break;
         end
         if (n == 200) begin
            check("req_accept_timeout", 32'd0, 32'd1);
            break;
         end
         n++;
         @(negedge clk);
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_drain(input bit fast);
      int n;
      n = 0;
      while ((fast ? qf.size() : q.size()) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if ((fast ? qf.size() : q.size()) != 0) check("drain_timeout", 32'(n), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int acc, a1, a2, idle_bad, base, rspb, n;
      idle_bad = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_cs",        32'(sram_cs),   32'd1);
      check("rst_oe",        32'(sram_oe),   32'd1);
      check("rst_we",        32'(sram_we),   32'd1);
      check("rst_io_oe",     32'(io_oe),     32'd0);
      check("rst_io_dout",   32'(io_dout),   32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      repeat (20) begin
         @(negedge clk);
         if (sram_cs !== 1'b1 || sram_oe !== 1'b1 || sram_we !== 1'b1 ||
             io_oe !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) idle_bad++;
      end
      check("idle_levels", 32'(idle_bad), 32'd0);

      // Write 0xA5: eight 4-cycle write strobes carrying 1,0,1,0,0,1,0,1.
      base = we_cnt;
      a1   = we_badw;
      a2   = dout_bad;
      do_req(1'b1, 8'hA5, 8'h00, acc);
      wait_drain(1'b0);
      check("wr_we_pulses",    32'(we_cnt - base),  32'd8);
      check("wr_bits",         32'(we_bits),        32'hA5);
      check("wr_we_width",     32'(we_badw - a1),   32'd0);
      check("wr_dout_stable",  32'(dout_bad - a2),  32'd0);

      // Read 0x3C from the model: io_oe must stay low throughout.
      rd_pat = 8'h3C;
      base   = io_oe_cnt;
      do_req(1'b0, 8'hFF, 8'h3C, acc);
      wait_drain(1'b0);
      check("rd_io_oe_low", 32'(io_oe_cnt - base), 32'd0);
      check("rd_rdata_held", 32'(rsp_rdata), 32'h3C);

      // Second request held off while busy, accepted right after DONE.
      do_req(1'b1, 8'h5A, 8'h00, a1);
      repeat (20) @(negedge clk);
      rd_pat = 8'h96;
      do_req(1'b0, 8'h00, 8'h96, a2);
      check("b2b_accept_gap", 32'(a2 - a1), 32'(B2B_GAP));
      wait_drain(1'b0);

      // Reset during STROBE of bit 3 of a write.
      base = we_cnt;
      do_req(1'b1, 8'hC3, 8'h00, acc);
      n = 0;
      while (we_cnt != base + 4 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_reached", 32'(we_cnt - base), 32'd4);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_we", 32'(sram_we), 32'd1);
      check("rst_mid_cs", 32'(sram_cs), 32'd1);
      check("rst_mid_io_oe", 32'(io_oe), 32'd0);
      q.delete();
      rspb = rsp_cnt;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (70) @(negedge clk);
      check("rst_mid_no_rsp", 32'(rsp_cnt - rspb), 32'd0);
      do_req(1'b1, 8'h3C, 8'h00, acc);
      wait_drain(1'b0);
      check("post_rst_bits", 32'(we_bits), 32'h3C);

      // Minimum-timing instance: write 0xFF, response 25 cycles after accept.
      @(negedge clk);
      req_valid_f = 1'b1;
      req_write_f = 1'b1;
      req_wdata_f = 8'hFF;
      check("fast_ready", 32'(req_ready_f), 32'd1);
      qf.push_back('{1'b1, 8'hFF, cyc + 1});
      @(negedge clk);
      req_valid_f = 1'b0;
      wait_drain(1'b1);
      check("strobe_exclusive", 32'(excl_bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
